// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera pixel capture block.
package cam_pkg;

  localparam int BPP_MIN = 1;
  localparam int BPP_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_VS  = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_STOPPING = 2'd3
  } cam_state_e;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Camera-side bus (beats in) and pixel-side bus (assembled pixels out).
interface cam_pixel_capture_if #(
  parameter int DW  = 8,
  parameter int BPP = 2
);
  logic [DW-1:0]     din;
  logic              vsync;
  logic              href;
  logic              pixel_valid;
  logic [DW*BPP-1:0] pixel;
  logic              hstart;
  logic              vstart;

  modport master (output din, vsync, href, input pixel_valid, pixel, hstart, vstart);
  modport slave  (input din, vsync, href, output pixel_valid, pixel, hstart, vstart);
endinterface

// File: rtl/cam_beat_packer.sv
// Collects BPP bus beats into one pixel word; msb_first picks beat order.
module cam_beat_packer #(
  parameter int DW  = 8,
  parameter int BPP = 2
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [DW-1:0]     din,
  input  logic              beat_en,
  input  logic              clr,
  input  logic              msb_first,
  output logic [DW*BPP-1:0] word,
  output logic              word_valid,
  output logic              partial
);
  localparam int CNTW = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(BPP - 1);

  logic [CNTW-1:0]     cnt_q, cnt_d, slot;
  logic [DW*BPP-1:0]   acc_q, acc_d, word_q, word_d;
  logic                valid_q, valid_d;

  // Place the incoming beat in its slot; publish the word on the last beat.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    word_d  = word_q;
    valid_d = 1'b0;
    slot    = msb_first ? (LAST - cnt_q) : cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (beat_en) begin
      acc_d[slot*DW +: DW] = din;
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        word_d  = acc_d;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Beat counter, accumulator and output word registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign partial    = (cnt_q != '0);

endmodule

// File: rtl/cam_pixel_capture.sv
// Camera pixel capture: frame-synchronised capture FSM, line/frame stats,
// line sanity checking. Optional test pattern under CAM_CAPTURE_TESTPAT_EN.
module cam_pixel_capture #(
  parameter int DW  = 8,
  parameter int BPP = 2,
  parameter int CW  = 16
) (
  input  logic                pclk,
  input  logic                rst_n,
  cam_pixel_capture_if.slave  cam,
  input  logic                msb_first,
  input  logic                start,
  input  logic                stop,
  input  logic                tp_en,
  output logic                busy,
  output logic [CW-1:0]       hlen,
  output logic [CW-1:0]       vlen,
  output logic                line_err,
  output logic [CW-1:0]       frame_cnt
);
  import cam_pkg::*;

  localparam int PW = DW * BPP;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [1:0] S_IDLE     = ST_IDLE;
  localparam logic [1:0] S_WAIT_VS  = ST_WAIT_VS;
  localparam logic [1:0] S_CAPTURE  = ST_CAPTURE;
  localparam logic [1:0] S_STOPPING = ST_STOPPING;

  if (BPP < BPP_MIN || BPP > BPP_MAX) begin : g_bpp_chk
    $error("cam_pixel_capture: BPP must be within 1..4");
  end

  logic [1:0]    state_q, state_d;
  logic          vsync_q, href_q;
  logic          vs_rise, vs_fall, href_rise, href_fall;
  logic          capturing, beat_en, frame_go;
  logic [PW-1:0] word;
  logic          word_valid, partial;
  logic [CW-1:0] px_q, px_d, px_now, lines_q, lines_d;
  logic [CW-1:0] hlen_q, hlen_d, vlen_q, vlen_d, frame_q, frame_d;
  logic          err_q, err_d, hflag_q, hflag_d, vflag_q, vflag_d;

  assign vs_rise   = cam.vsync & ~vsync_q;
  assign vs_fall   = ~cam.vsync & vsync_q;
  assign href_rise = cam.href & ~href_q;
  assign href_fall = ~cam.href & href_q;
  assign capturing = (state_q == S_CAPTURE) || (state_q == S_STOPPING);
  assign beat_en   = capturing & cam.href & ~cam.vsync;
  assign frame_go  = vs_fall & (capturing | (state_q == S_WAIT_VS & ~stop));

  cam_beat_packer #(.DW(DW), .BPP(BPP)) u_packer (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .din       (cam.din),
    .beat_en   (beat_en),
    .clr       (~cam.href | cam.vsync),
    .msb_first (msb_first),
    .word      (word),
    .word_valid(word_valid),
    .partial   (partial)
  );

  // Capture FSM; stop beats start, and start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start && !stop) state_d = S_WAIT_VS;
      S_WAIT_VS:  if (stop) state_d = S_IDLE; else if (vs_fall) state_d = S_CAPTURE;
      S_CAPTURE:  if (stop) state_d = S_STOPPING;
      S_STOPPING: if (vs_rise) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Line/frame counters, line checking and start-of-line/frame markers.
  always_comb begin
    px_now  = word_valid ? CW'(sat_inc(32'(px_q), 32'(CNT_MAX))) : px_q;
    px_d    = px_now;
    lines_d = lines_q;
    hlen_d  = hlen_q;
    vlen_d  = vlen_q;
    frame_d = frame_q;
    err_d   = 1'b0;
    hflag_d = hflag_q & ~word_valid;
    vflag_d = vflag_q & ~word_valid;
    if (frame_go) begin
      lines_d = '0;
      px_d    = '0;
      vflag_d = 1'b1;
    end
    if (beat_en && href_rise) begin
      lines_d = CW'(sat_inc(32'(lines_q), 32'(CNT_MAX)));
      px_d    = '0;
      hflag_d = 1'b1;
    end
    if (capturing && href_fall && !vsync_q) begin
      hlen_d = px_now;
      err_d  = partial || ((lines_q > CW'(1)) && (px_now != hlen_q));
      px_d   = '0;
    end
    if (capturing && vs_rise) begin
      vlen_d = lines_q;
      if (lines_q != '0) frame_d = frame_q + 1'b1;
    end
  end

  // State, edge-detect and statistics registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      px_q    <= '0;
      lines_q <= '0;
      hlen_q  <= '0;
      vlen_q  <= '0;
      frame_q <= '0;
      err_q   <= 1'b0;
      hflag_q <= 1'b0;
      vflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= cam.vsync;
      href_q  <= cam.href;
      px_q    <= px_d;
      lines_q <= lines_d;
      hlen_q  <= hlen_d;
      vlen_q  <= vlen_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      hflag_q <= hflag_d;
      vflag_q <= vflag_d;
    end
  end

`ifdef CAM_CAPTURE_TESTPAT_EN
  localparam int HALF = PW / 2;
  logic [CW-1:0] line_idx;
  logic [PW-1:0] pat_now, pat_q;
  assign line_idx = lines_q - 1'b1;
  assign pat_now  = PW'({HALF'(line_idx), HALF'(px_q)});

  // Hold the last pattern value so pixel stays stable between strobes.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)          pat_q <= '0;
    else if (word_valid) pat_q <= pat_now;
  end

  assign cam.pixel = tp_en ? (word_valid ? pat_now : pat_q) : word;
`else
  logic unused_tp;
  assign unused_tp = tp_en;
  assign cam.pixel = word;
`endif

  assign cam.pixel_valid = word_valid;
  assign cam.hstart      = word_valid & hflag_q;
  assign cam.vstart      = word_valid & vflag_q;
  assign busy            = (state_q != S_IDLE);
  assign hlen            = hlen_q;
  assign vlen            = vlen_q;
  assign line_err        = err_q;
  assign frame_cnt       = frame_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
module tb_cam_pixel_capture;
  localparam int DW = 8, BPP = 2, CW = 16;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic msb_first = 1'b0, start = 1'b0, stop = 1'b0, tp_en = 1'b0;
  logic busy, line_err;
  logic [CW-1:0] hlen, vlen, frame_cnt;

  int tests_run = 0, tests_failed = 0;
  int n_pv = 0, n_hs = 0, n_vs = 0, n_err = 0, n_bad = 0;

  cam_pixel_capture_if #(.DW(DW), .BPP(BPP)) cam_if ();

  cam_pixel_capture #(.DW(DW), .BPP(BPP), .CW(CW)) dut (
    .pclk(pclk), .rst_n(rst_n), .cam(cam_if), .msb_first(msb_first),
    .start(start), .stop(stop), .tp_en(tp_en), .busy(busy), .hlen(hlen),
    .vlen(vlen), .line_err(line_err), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (rst_n) begin
      if (cam_if.pixel_valid) n_pv++;
      if (cam_if.pixel_valid && cam_if.hstart) n_hs++;
      if (cam_if.pixel_valid && cam_if.vstart) n_vs++;
      if ((cam_if.hstart || cam_if.vstart) && !cam_if.pixel_valid) n_bad++;
      if (line_err) n_err++;
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; start = 0; stop = 0; msb_first = 0; tp_en = 0;
    cam_if.din = '0; cam_if.vsync = 0; cam_if.href = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic vs_pulse();
    cam_if.vsync = 1'b1; repeat (3) tick();
    cam_if.vsync = 1'b0; repeat (3) tick();
  endtask

  task automatic send_line(input int nbeats, input logic [7:0] base);
    cam_if.href = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      cam_if.din = base + 8'(i);
      tick();
    end
    cam_if.href = 1'b0; cam_if.din = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    cam_if.din = 8'h5A; cam_if.vsync = 0; cam_if.href = 1;
    start = 1'b1;
    repeat (2) tick();
    tests_run++; if (cam_if.pixel_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_pv: got %b expected 0", cam_if.pixel_valid); end
    tests_run++; if (cam_if.pixel !== 16'h0) begin tests_failed++; $display("FAIL reset_pixel: got %h expected 0000", cam_if.pixel); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if ({hlen, vlen, frame_cnt, line_err} !== 49'h0) begin tests_failed++; $display("FAIL reset_stats: got %h %h %h %b expected all 0", hlen, vlen, frame_cnt, line_err); end
    reset_dut();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_two_frames();
    int b_pv, b_hs, b_vs, b_err;
    reset_dut();
    pulse_start();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %b expected 1", busy); end
    b_pv = n_pv; b_hs = n_hs; b_vs = n_vs; b_err = n_err;
    for (int f = 0; f < 2; f++) begin
      vs_pulse();
      for (int l = 0; l < 4; l++) send_line(16, 8'h00);
    end
    vs_pulse();
    tests_run++; if (n_pv - b_pv !== 64) begin tests_failed++; $display("FAIL basic_strobes: got %0d expected 64", n_pv - b_pv); end
    tests_run++; if (n_hs - b_hs !== 8) begin tests_failed++; $display("FAIL basic_hstart: got %0d expected 8", n_hs - b_hs); end
    tests_run++; if (n_vs - b_vs !== 2) begin tests_failed++; $display("FAIL basic_vstart: got %0d expected 2", n_vs - b_vs); end
    tests_run++; if (n_err - b_err !== 0) begin tests_failed++; $display("FAIL basic_line_err: got %0d expected 0", n_err - b_err); end
    tests_run++; if (hlen !== 16'd8) begin tests_failed++; $display("FAIL basic_hlen: got %0d expected 8", hlen); end
    tests_run++; if (vlen !== 16'd4) begin tests_failed++; $display("FAIL basic_vlen: got %0d expected 4", vlen); end
    tests_run++; if (frame_cnt !== 16'd2) begin tests_failed++; $display("FAIL basic_frame_cnt: got %0d expected 2", frame_cnt); end
    tests_run++; if (cam_if.pixel !== 16'h0F0E) begin tests_failed++; $display("FAIL basic_last_pixel: got %h expected 0f0e", cam_if.pixel); end
  endtask

  task automatic test_byte_order();
    reset_dut();
    pulse_start();
    vs_pulse();
    msb_first = 1'b0;
    cam_if.href = 1'b1; cam_if.din = 8'hAB; tick();
    cam_if.din = 8'hCD; tick();
    tests_run++; if (cam_if.pixel_valid !== 1'b1) begin tests_failed++; $display("FAIL order_lsb_pv: got %b expected 1", cam_if.pixel_valid); end
    tests_run++; if (cam_if.pixel !== 16'hCDAB) begin tests_failed++; $display("FAIL order_lsb_pixel: got %h expected cdab", cam_if.pixel); end
    tests_run++; if ({cam_if.vstart, cam_if.hstart} !== 2'b11) begin tests_failed++; $display("FAIL order_first_flags: got %b expected 11", {cam_if.vstart, cam_if.hstart}); end
    cam_if.href = 1'b0; repeat (3) tick();
    tests_run++; if ({cam_if.pixel_valid, cam_if.pixel} !== {1'b0, 16'hCDAB}) begin tests_failed++; $display("FAIL order_hold: got %b %h expected 0 cdab", cam_if.pixel_valid, cam_if.pixel); end
    msb_first = 1'b1;
    cam_if.href = 1'b1; cam_if.din = 8'hAB; tick();
    cam_if.din = 8'hCD; tick();
    tests_run++; if (cam_if.pixel !== 16'hABCD) begin tests_failed++; $display("FAIL order_msb_pixel: got %h expected abcd", cam_if.pixel); end
    tests_run++; if ({cam_if.pixel_valid, cam_if.vstart, cam_if.hstart} !== 3'b101) begin tests_failed++; $display("FAIL order_line2_flags: got %b expected 101", {cam_if.pixel_valid, cam_if.vstart, cam_if.hstart}); end
    cam_if.href = 1'b0; repeat (3) tick();
  endtask

  task automatic test_midframe_start();
    int b_pv;
    reset_dut();
    b_pv = n_pv;
    cam_if.href = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cam_if.din = 8'(i);
      start = (i == 3);
      tick();
    end
    start = 1'b0; cam_if.href = 1'b0; repeat (4) tick();
    send_line(16, 8'h40);
    tests_run++; if (n_pv - b_pv !== 0) begin tests_failed++; $display("FAIL midstart_no_strobe: got %0d expected 0", n_pv - b_pv); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midstart_busy: got %b expected 1", busy); end
    vs_pulse();
    cam_if.href = 1'b1; cam_if.din = 8'h11; tick();
    cam_if.din = 8'h22; tick();
    tests_run++; if ({cam_if.pixel_valid, cam_if.vstart, cam_if.hstart} !== 3'b111) begin tests_failed++; $display("FAIL midstart_first_flags: got %b expected 111", {cam_if.pixel_valid, cam_if.vstart, cam_if.hstart}); end
    tests_run++; if (cam_if.pixel !== 16'h2211) begin tests_failed++; $display("FAIL midstart_pixel: got %h expected 2211", cam_if.pixel); end
    cam_if.href = 1'b0; repeat (3) tick();
  endtask

  task automatic test_short_line();
    int b_pv, b_err;
    reset_dut();
    pulse_start();
    vs_pulse();
    b_pv = n_pv; b_err = n_err;
    cam_if.href = 1'b1;
    for (int i = 0; i < 15; i++) begin cam_if.din = 8'(i); tick(); end
    cam_if.href = 1'b0; tick();
    tests_run++; if (line_err !== 1'b1) begin tests_failed++; $display("FAIL short_err_pulse: got %b expected 1", line_err); end
    tick();
    tests_run++; if (line_err !== 1'b0) begin tests_failed++; $display("FAIL short_err_width: got %b expected 0", line_err); end
    tests_run++; if (n_pv - b_pv !== 7) begin tests_failed++; $display("FAIL short_strobes: got %0d expected 7", n_pv - b_pv); end
    tests_run++; if (hlen !== 16'd7) begin tests_failed++; $display("FAIL short_hlen: got %0d expected 7", hlen); end
    repeat (3) tick();
    send_line(16, 8'h00);
    tests_run++; if (n_err - b_err !== 2) begin tests_failed++; $display("FAIL short_len_change_err: got %0d expected 2", n_err - b_err); end
    tests_run++; if (hlen !== 16'd8) begin tests_failed++; $display("FAIL short_hlen_next: got %0d expected 8", hlen); end
    send_line(16, 8'h00);
    tests_run++; if (n_err - b_err !== 2) begin tests_failed++; $display("FAIL short_same_len_no_err: got %0d expected 2", n_err - b_err); end
  endtask

  task automatic test_stop();
    int b_pv;
    reset_dut();
    pulse_start();
    vs_pulse();
    send_line(16, 8'h00);
    stop = 1'b1; tick(); stop = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL stop_busy_during: got %b expected 1", busy); end
    send_line(16, 8'h00);
    cam_if.vsync = 1'b1; tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stop_busy_after: got %b expected 0", busy); end
    tests_run++; if (frame_cnt !== 16'd1) begin tests_failed++; $display("FAIL stop_frame_cnt: got %0d expected 1", frame_cnt); end
    tests_run++; if (vlen !== 16'd2) begin tests_failed++; $display("FAIL stop_vlen: got %0d expected 2", vlen); end
    repeat (2) tick();
    cam_if.vsync = 1'b0; repeat (3) tick();
    b_pv = n_pv;
    send_line(16, 8'h00);
    tests_run++; if (n_pv - b_pv !== 0) begin tests_failed++; $display("FAIL stop_no_strobes: got %0d expected 0", n_pv - b_pv); end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stop_start_same_cycle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midline();
    int b_pv;
    reset_dut();
    pulse_start();
    vs_pulse();
    send_line(16, 8'h10);
    cam_if.href = 1'b1;
    for (int i = 0; i < 5; i++) begin cam_if.din = 8'h30 + 8'(i); tick(); end
    rst_n = 1'b0;
    #1;
    tests_run++; if ({cam_if.pixel_valid, cam_if.pixel, cam_if.hstart, cam_if.vstart} !== 19'h0) begin tests_failed++; $display("FAIL rstmid_pixel_side: got %b %h %b %b expected all 0", cam_if.pixel_valid, cam_if.pixel, cam_if.hstart, cam_if.vstart); end
    tests_run++; if ({busy, hlen, vlen, frame_cnt, line_err} !== 50'h0) begin tests_failed++; $display("FAIL rstmid_status: got %b %h %h %h %b expected all 0", busy, hlen, vlen, frame_cnt, line_err); end
    tick(); tick();
    rst_n = 1'b1;
    b_pv = n_pv;
    repeat (4) tick();
    cam_if.href = 1'b0; repeat (3) tick();
    vs_pulse();
    send_line(16, 8'h00);
    tests_run++; if (n_pv - b_pv !== 0) begin tests_failed++; $display("FAIL rstmid_no_restart: got %0d expected 0", n_pv - b_pv); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
  endtask

  task automatic test_tp();
    logic [15:0] exp1, exp2;
`ifdef CAM_CAPTURE_TESTPAT_EN
    exp1 = 16'h0001; exp2 = 16'h0100;
`else
    exp1 = 16'h0403; exp2 = 16'h0605;
`endif
    reset_dut();
    pulse_start();
    vs_pulse();
    tp_en = 1'b1;
    cam_if.href = 1'b1;
    for (int i = 1; i <= 4; i++) begin cam_if.din = 8'(i); tick(); end
    tests_run++; if ({cam_if.pixel_valid, cam_if.pixel} !== {1'b1, exp1}) begin tests_failed++; $display("FAIL tp_line0_px1: got %b %h expected 1 %h", cam_if.pixel_valid, cam_if.pixel, exp1); end
    cam_if.href = 1'b0; repeat (4) tick();
    tests_run++; if (cam_if.pixel !== exp1) begin tests_failed++; $display("FAIL tp_hold: got %h expected %h", cam_if.pixel, exp1); end
    cam_if.href = 1'b1; cam_if.din = 8'h05; tick();
    cam_if.din = 8'h06; tick();
    tests_run++; if (cam_if.pixel !== exp2) begin tests_failed++; $display("FAIL tp_line1_px0: got %h expected %h", cam_if.pixel, exp2); end
    cam_if.href = 1'b0; tp_en = 1'b0; repeat (3) tick();
  endtask

  initial begin
    cam_if.din = '0; cam_if.vsync = 1'b0; cam_if.href = 1'b0;
    test_reset();
    test_two_frames();
    test_byte_order();
    test_midframe_start();
    test_short_line();
    test_stop();
    test_reset_midline();
    test_tp();
    tests_run++; if (n_bad !== 0) begin tests_failed++; $display("FAIL flags_without_valid: got %0d expected 0", n_bad); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
